// File: rtl/rom_fetch_unit_pkg.sv
// rom_fetch_unit_pkg: shared widths, reset PC and FSM state encodings for the fetch unit
package rom_fetch_unit_pkg;
    localparam int              DEF_ADDR_W     = 16;
    localparam int              DEF_DATA_W     = 32;
    localparam int              DEF_FIFO_DEPTH = 4;
    localparam logic [15:0]     DEF_RESET_PC   = 16'h0000;
    localparam logic [0:0]      ST_RUN         = 1'b0;
    localparam logic [0:0]      ST_FAULT       = 1'b1;
endpackage

// File: rtl/rom_fetch_unit_fifo.sv
// rom_fetch_unit_fifo: prefetch FIFO with flush, occupancy count and a head read straight from storage registers
module rom_fetch_unit_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [AW:0]   count_o,
    output logic [W-1:0]  head_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;

    // storage, pointers and count; flush drops contents but leaves storage untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
            if (push_i && !pop_i) cnt_q <= cnt_q + 1'b1;
            else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: boot-ROM fetch stage with prefetch FIFO and redirect flush; FETCH_WRAP_FAULT_EN enables PC-wrap fault
module rom_fetch_unit
    import rom_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_fault
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     count;
    logic              push, pop, wrap;

    assign pop  = instr_valid && instr_ready;
    assign push = state_q == ST_RUN && fetch_en && !redirect_valid && (count < CW'(FIFO_DEPTH) || pop);

`ifdef FETCH_WRAP_FAULT_EN
    assign wrap        = push && &pc_q;
    assign fetch_fault = state_q == ST_FAULT;
`else
    assign wrap        = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // redirect wins; a wrapping push parks the PC at all-ones and enters FAULT
    always_comb begin
        pc_d    = redirect_valid ? redirect_pc : (push && !wrap) ? pc_q + 1'b1 : pc_q;
        state_d = redirect_valid ? ST_RUN : wrap ? ST_FAULT : state_q;
    end

    // fetch PC and FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    rom_fetch_unit_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({pc_q, rom_data}),
        .count_o (count),
        .head_o  ({instr_pc, instr})
    );

    assign rom_address = pc_q;
    assign instr_valid = count != '0;
endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb_rom_fetch_unit: queue-based reference model with per-cycle compare, directed scenarios and random traffic
module tb_rom_fetch_unit;
`ifdef FETCH_WRAP_FAULT_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rom_address;
    logic [31:0] rom_data;
    logic        fe = 1'b1, rdy = 1'b1, rv = 1'b0;
    logic [15:0] rpc = 16'h0;
    logic        instr_valid, fetch_fault;
    logic [31:0] instr;
    logic [15:0] instr_pc;

    int tests = 0;
    int fails = 0;

    logic [15:0] q[$];
    logic [15:0] mpc = 16'h0;
    bit          mfault = 1'b0;
    bit          mp, mu;

    function automatic logic [31:0] rom(input logic [15:0] a);
        return 32'(a) + 32'h100;
    endfunction

    assign rom_data = rom(rom_address);

    rom_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .fetch_en       (fe),
        .redirect_valid (rv),
        .redirect_pc    (rpc),
        .instr_valid    (instr_valid),
        .instr_ready    (rdy),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // reference model: FIFO as a queue of fetch addresses
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mpc    = 16'h0;
            mfault = 1'b0;
        end else begin
            mp = q.size() != 0 && rdy;
            mu = !mfault && fe && !rv && (q.size() < 4 || mp);
            if (rv) begin
                q.delete();
                mpc    = rpc;
                mfault = 1'b0;
            end else begin
                if (mp) void'(q.pop_front());
                if (mu) begin
                    q.push_back(mpc);
                    if (WRAP && mpc == 16'hFFFF) mfault = 1'b1;
                    else mpc = mpc + 16'h1;
                end
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        chk("rom_address", 32'(rom_address), 32'(mpc));
        chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
        chk("fetch_fault", 32'(fetch_fault), 32'(mfault));
        if (q.size() != 0) begin
            chk("instr_pc", 32'(instr_pc), 32'(q[0]));
            chk("instr", instr, rom(q[0]));
        end
        if (!rst_n) begin
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        end
    end

    initial begin
        @(negedge clk);
        chk("reset_valid", 32'(instr_valid), 32'h0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_addr", 32'(rom_address), 32'h0);
        chk("reset_fault", 32'(fetch_fault), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_instr", instr, 32'h100);
        chk("first_pc", 32'(instr_pc), 32'h0);
        @(negedge clk);
        chk("second_instr", instr, 32'h101);
        @(negedge clk);
        chk("third_pc", 32'(instr_pc), 32'h2);
        rdy = 1'b0;
        repeat (6) @(negedge clk);
        chk("stall_addr", 32'(rom_address), 32'h6);
        chk("stall_instr", instr, 32'h102);
        chk("stall_valid", 32'(instr_valid), 32'h1);
        rdy = 1'b1;
        @(negedge clk);
        chk("fullpop_addr", 32'(rom_address), 32'h7);
        chk("fullpop_pc", 32'(instr_pc), 32'h3);
        rv = 1'b1; rpc = 16'h0040;
        @(negedge clk);
        chk("redir_valid", 32'(instr_valid), 32'h0);
        chk("redir_addr", 32'(rom_address), 32'h40);
        rv = 1'b0;
        @(negedge clk);
        chk("redir_pc", 32'(instr_pc), 32'h40);
        chk("redir_instr", instr, 32'h140);
        rv = 1'b1; rpc = 16'hFFFE;
        @(negedge clk);
        rv = 1'b0;
        @(negedge clk);
        chk("wrap_pc0", 32'(instr_pc), 32'hFFFE);
        @(negedge clk);
        chk("wrap_pc1", 32'(instr_pc), 32'hFFFF);
        chk("wrap_fault", 32'(fetch_fault), 32'(WRAP));
        chk("wrap_addr", 32'(rom_address), WRAP ? 32'hFFFF : 32'h0);
        @(negedge clk);
        chk("wrap_valid", 32'(instr_valid), WRAP ? 32'h0 : 32'h1);
        rv = 1'b1; rpc = 16'h0010;
        @(negedge clk);
        chk("clear_fault", 32'(fetch_fault), 32'h0);
        chk("clear_addr", 32'(rom_address), 32'h10);
        rv = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                chk("async_valid", 32'(instr_valid), 32'h0);
                chk("async_instr", instr, 32'h0);
                chk("async_addr", 32'(rom_address), 32'h0);
                rst_n = 1'b1;
            end
            fe  = $urandom_range(0, 9) != 0;
            rdy = $urandom_range(0, 9) < 7;
            rv  = $urandom_range(0, 19) == 0;
            rpc = $urandom_range(0, 1) != 0 ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
